vga_scanout: RTL and testbench
==============================

# vga_scanout

Downstream stage of the pixel pipeline: consumes RGB332 pixel bytes from the PPU over the stb/ack byte handshake, buffers them in a small FIFO, and drives VGA timing (hsync, vsync, data-enable) and 8-bit colour, one pixel per clock. It also generates the one-cycle `sync` frame pulse that the PPU uses to restart its counters.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width
- `V_BP`, 33, vertical back porch
- `FIFO_DEPTH`, 16, pixel FIFO entries (power of two, ≥4)

Ports:
- `clk`  in  1  pixel clock; all logic is on its rising edge
- `rst`  in  1  reset; one clock domain; reset is synchronous and active-low
- `data_i`  in  8  pixel byte {R[2:0],G[2:0],B[1:0]}
- `stb_i`  in  1  upstream strobe; held high until `ack_i` is seen
- `ack_i`  out  1  one-cycle accept pulse
- `sync`  out  1  one-cycle frame pulse to the PPU
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `de`  out  1  data enable (visible pixel)
- `r`, `g`  out  3 each  colour
- `b`  out  2  colour
- `underrun`  out  1  sticky: a visible pixel found the FIFO empty

## Operation
- Counters: `h` 0..H_TOTAL-1 with H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP. `v` 0..V_TOTAL-1 defined the same way. `h` increments every clock. At H_TOTAL-1, `h` wraps to 0 and `v` increments. At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- Visible region: h<H_ACTIVE and v<V_ACTIVE.
- hsync is low when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
- vsync is low when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC.
- Input accept: a byte is pushed in a cycle where `stb_i`=1, `ack_i`=0, the FIFO is not full and it is not a flush cycle. `ack_i` goes high for exactly the next cycle. While `ack_i`=1 no accept occurs, which covers the stb drop delay.
- Pop: in a visible cycle, the FIFO head is popped when the FIFO is non-empty.
  - The popped byte drives r/g/b.
  - If the FIFO is empty, r/g/b=0 and `underrun` is set. `underrun` clears only on reset.
- Simultaneous push and pop: occupancy is unchanged. Pop reads the old head, so a byte pushed into an empty FIFO is never popped in the same cycle.
- Flush / sync: at counter position h=0, v=V_ACTIVE (start of vertical blank):
  - `sync` pulses high for that cycle.
  - The FIFO is emptied.
  - No accept occurs in that cycle.
  - Stale bytes are discarded so that every frame starts aligned.
- Outside the visible region: de=0 and r/g/b=0.

## Timing
- All outputs are registered. Outputs in cycle n+1 reflect counter position (h,v) from cycle n, i.e. a fixed 1-cycle latency for hsync, vsync, de, rgb and sync.
- Push-to-earliest-display latency: 2 cycles (push edge, then pop edge, then output register).
- Reset (rst=0 at an edge):
  - h=v=0, FIFO empty.
  - Outputs: `ack_i`=0, `sync`=0, `hsync`=1, `vsync`=1, `de`=0, r=g=b=0, `underrun`=0.
  - Reset asserted mid-line or mid-frame takes effect at the next edge: counters restart from 0 and FIFO contents are lost.
- First clock after reset release: the position being output is (0,0), i.e. visible with an empty FIFO. The `underrun` flag is therefore expected at startup unless data is preloaded. Benches preload or ignore the first line.
- Full FIFO: `stb_i` may stay high indefinitely. `ack_i` stays low until a pop frees an entry; the accept then occurs in that following cycle.
- Throughput: at most one accept per 2 cycles, which bounds sustained input to 50% of the clock. The PPU must prefill during blanking. H blanking of 160 clocks is the budget.

## Test plan
- Reset: hold rst=0 for 3 clocks with stb_i=1 -> ack_i=0, sync=0, hsync=1, vsync=1, de=0, rgb=0, underrun=0 throughout.
- Line timing (defaults, no data): hsync low exactly on output cycles for h=656..751 (96 clocks). de high for 640 clocks per line. Line period 800. vsync low for lines 490..491. sync pulses once per 420000 clocks at position (0,480).
- Data path: preload bytes 0xE0, 0x1C, 0x03, 0xFF before a visible line -> first four visible pixels are (r,g,b)=(7,0,0), (0,7,0), (0,0,3), (7,7,3). ack_i pulses exactly once per byte, never on consecutive cycles.
- Backpressure: FIFO_DEPTH=16, stb_i held high during blanking -> exactly 16 acks, then ack_i stays low until the first visible pop. The next ack occurs one cycle after that pop.
- Underrun: FIFO holds 3 bytes at line start -> pixels 0..2 carry the data, pixel 3 is black and underrun goes 1 and stays 1 until reset.
- Flush and mid-frame reset: 5 bytes left in the FIFO at (0,480) -> FIFO empty after the sync cycle and no ack in the sync cycle. Asserting rst=0 at h=300 resets counters so that hsync next falls 656 clocks after release.

Source files
------------

// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
//
// Last stage of the pixel pipeline. RGB332 bytes arrive from the PPU over a
// stb/ack byte handshake and are buffered in a small FIFO. The block runs
// the VGA raster counters and pops one byte per visible clock to drive the
// colour outputs, together with hsync, vsync and data-enable. At the start
// of vertical blanking it emits a one-cycle `sync` pulse so the PPU can
// restart its counters. On the same cycle the FIFO is flushed, so every
// frame starts aligned.
//
// Ports
//   clk       in   pixel clock, all logic on its rising edge
//   rst       in   synchronous, active-low reset
//   data_i    in   [7:0] pixel byte {R[2:0], G[2:0], B[1:0]}
//   stb_i     in   upstream strobe, held until ack_i is seen
//   ack_i     out  one-cycle accept pulse, the cycle after a push
//   sync      out  one-cycle frame pulse at (h=0, v=V_ACTIVE)
//   hsync     out  active-low horizontal sync
//   vsync     out  active-low vertical sync
//   de        out  data enable, high for visible pixels
//   r, g      out  [2:0] colour
//   b         out  [1:0] colour
//   underrun  out  sticky, set when a visible pixel found the FIFO empty
//
// All outputs are registered. Each output reflects the counter position
// of the previous clock.
// ---------------------------------------------------------------------------
module vga_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       stb_i,
    output logic       ack_i,
    output logic       sync,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [2:0] r,
    output logic [2:0] g,
    output logic [1:0] b,
    output logic       underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // One extra bit lets the sync-end boundary equal H_TOTAL (zero back porch).
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [CW-1:0] FULL_COUNT   = CW'(FIFO_DEPTH);

    // Raster position
    logic [HW-1:0] hCount_q, hCount_d;
    logic [VW-1:0] vCount_q, vCount_d;

    // Pixel FIFO
    logic [7:0]    fifoMem_q [FIFO_DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;

    // Registered outputs
    logic       ackOut_q;
    logic       syncOut_q;
    logic       hsync_q;
    logic       vsync_q;
    logic       de_q;
    logic [7:0] pixel_q;
    logic       underrun_q;

    // Decodes of the current position and FIFO state
    logic visible;
    logic flushCycle;
    logic hsyncActive;
    logic vsyncActive;
    logic fifoEmpty;
    logic fifoFull;
    logic pushEn;
    logic popEn;

    assign visible     = (hCount_q < H_VIS_END) && (vCount_q < V_VIS_END);
    assign flushCycle  = (hCount_q == '0) && (vCount_q == V_VIS_END);
    assign hsyncActive = (hCount_q >= H_SYNC_START) && (hCount_q < H_SYNC_END);
    assign vsyncActive = (vCount_q >= V_SYNC_START) && (vCount_q < V_SYNC_END);

    assign fifoEmpty   = (count_q == '0);
    assign fifoFull    = (count_q == FULL_COUNT);

    // ack_i being high blocks a second accept. This covers the cycle in
    // which the PPU has not yet dropped or advanced its strobe.
    assign pushEn      = stb_i && !ackOut_q && !fifoFull && !flushCycle;
    assign popEn       = visible && !fifoEmpty;

    // Raster counters. h wraps every line, and v advances on the h wrap.
    always_comb begin
        hCount_d = hCount_q + 1'b1;
        vCount_d = vCount_q;
        if (hCount_q == H_LAST) begin
            hCount_d = '0;
            if (vCount_q == V_LAST) begin
                vCount_d = '0;
            end else begin
                vCount_d = vCount_q + 1'b1;
            end
        end
    end

    // FIFO pointer and occupancy update. The flush cycle is never visible
    // and never accepts, so clearing everything there loses no transfer.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushEn) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({pushEn, popEn})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flushCycle) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end
    end

    // The storage array needs no reset. The pointers and the count decide
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            fifoMem_q[wrPtr_q] <= data_i;
        end
    end

    // State and output registers. A pop reads the old head, so a byte
    // written this cycle is never shown in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hCount_q   <= '0;
            vCount_q   <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            ackOut_q   <= 1'b0;
            syncOut_q  <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            de_q       <= 1'b0;
            pixel_q    <= 8'h00;
            underrun_q <= 1'b0;
        end else begin
            hCount_q   <= hCount_d;
            vCount_q   <= vCount_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            ackOut_q   <= pushEn;
            syncOut_q  <= flushCycle;
            hsync_q    <= ~hsyncActive;
            vsync_q    <= ~vsyncActive;
            de_q       <= visible;
            pixel_q    <= popEn ? fifoMem_q[rdPtr_q] : 8'h00;
            underrun_q <= underrun_q | (visible & fifoEmpty);
        end
    end

    assign ack_i    = ackOut_q;
    assign sync     = syncOut_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign de       = de_q;
    assign r        = pixel_q[7:5];
    assign g        = pixel_q[4:2];
    assign b        = pixel_q[1:0];
    assign underrun = underrun_q;

endmodule

// File: tb/tb_vga_scanout.sv
// ---------------------------------------------------------------------------
// tb_vga_scanout
//
// Self-checking bench for vga_scanout. It uses a reduced raster so that
// several complete frames fit in a short run. A cycle-level reference keeps
// the raster position as plain modular arithmetic and the FIFO as a queue.
// Each test task compares the DUT outputs with that reference, and also
// with the fixed values that the timing rules dictate.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_scanout;

    localparam int HA = 32, HF = 8, HS = 12, HB = 24;
    localparam int VA = 6,  VF = 2, VS = 2,  VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       stb_i = 1'b0;
    logic       ack_i, sync, hsync, vsync, de, underrun;
    logic [2:0] r, g;
    logic [1:0] b;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .stb_i(stb_i), .ack_i(ack_i),
        .sync(sync), .hsync(hsync), .vsync(vsync), .de(de),
        .r(r), .g(g), .b(b), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cycleNo = 0;

    // Reference state: the raster position about to be sampled, the FIFO
    // contents, the bytes the upstream still wants to send, and the outputs
    // expected after the next edge.
    int         mh = 0, mv = 0;
    logic [7:0] fifoQ[$];
    logic [7:0] srcQ[$];
    logic       eAck = 1'b0, eSync = 1'b0, eHs = 1'b1, eVs = 1'b1, eDe = 1'b0, eUnder = 1'b0;
    logic [7:0] ePix = 8'h00;

    wire  [12:0] obsVec = {ack_i, sync, hsync, vsync, de, r, g, b, underrun};
    logic [12:0] expVec;

    localparam logic [12:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

    // Present upstream data, advance the reference by one clock, then step
    // the clock and sample 1ns after the edge.
    task automatic tick();
        bit         vis, fl, pushNow, popNow;
        logic [7:0] pix;
        stb_i  = (srcQ.size() > 0);
        data_i = (srcQ.size() > 0) ? srcQ[0] : 8'h00;
        if (!rst) begin
            mh = 0; mv = 0;
            fifoQ.delete();
            eAck = 1'b0; eSync = 1'b0; eHs = 1'b1; eVs = 1'b1;
            eDe = 1'b0; ePix = 8'h00; eUnder = 1'b0;
        end else begin
            vis     = (mh < HA) && (mv < VA);
            fl      = (mh == 0) && (mv == VA);
            pushNow = stb_i && !eAck && (fifoQ.size() < DEPTH) && !fl;
            popNow  = vis && (fifoQ.size() > 0);
            pix     = 8'h00;
            if (popNow) pix = fifoQ.pop_front();
            if (fl) fifoQ.delete();
            if (pushNow) begin
                fifoQ.push_back(data_i);
                void'(srcQ.pop_front());
            end
            eAck   = pushNow;
            eSync  = fl;
            eHs    = !((mh >= HA + HF) && (mh < HA + HF + HS));
            eVs    = !((mv >= VA + VF) && (mv < VA + VF + VS));
            eDe    = vis;
            ePix   = pix;
            eUnder = eUnder || (vis && !popNow);
            mh = mh + 1;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end
        expVec = {eAck, eSync, eHs, eVs, eDe, ePix, eUnder};
        @(posedge clk);
        #1;
        cycleNo++;
    endtask

    // Run the clock until the reference reaches a raster position.
    task automatic advance_to(input int th, input int tv);
        for (int i = 0; i < 2 * HT * VT; i++) begin
            if (mh == th && mv == tv) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        srcQ.delete();
        srcQ.push_back(8'hA5);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obsVec !== RESET_VEC)
                $display("[TB] FAIL reset_outputs cycle=%0d got=%h want=%h", i, obsVec, RESET_VEC);
            else passed++;
        end
        srcQ.delete();
    endtask

    task automatic test_line_timing();
        int hsLow = 0, hsFirst = -1, deCnt = 0;
        int vsLow = 0, vsFirst = -1, syncCnt = 0, syncAt = -1;
        rst = 1'b1;
        for (int n = 0; n < HT * VT; n++) begin
            tick();
            checks++;
            if (obsVec !== expVec)
                $display("[TB] FAIL timing_model cyc=%0d got=%h want=%h", cycleNo, obsVec, expVec);
            else passed++;
            if (n == 0) begin
                checks++;
                if (underrun !== 1'b1)
                    $display("[TB] FAIL startup_underrun got=%b want=1", underrun);
                else passed++;
            end
            if (n < HT) begin
                if (!hsync) begin
                    if (hsFirst < 0) hsFirst = n;
                    hsLow++;
                end
                if (de) deCnt++;
            end
            if (!vsync) begin
                if (vsFirst < 0) vsFirst = n;
                vsLow++;
            end
            if (sync) begin
                syncCnt++;
                syncAt = n;
            end
        end
        checks++;
        if (hsLow !== HS) $display("[TB] FAIL hsync_width got=%0d want=%0d", hsLow, HS);
        else passed++;
        checks++;
        if (hsFirst !== HA + HF) $display("[TB] FAIL hsync_start got=%0d want=%0d", hsFirst, HA + HF);
        else passed++;
        checks++;
        if (deCnt !== HA) $display("[TB] FAIL de_per_line got=%0d want=%0d", deCnt, HA);
        else passed++;
        checks++;
        if (vsLow !== VS * HT) $display("[TB] FAIL vsync_width got=%0d want=%0d", vsLow, VS * HT);
        else passed++;
        checks++;
        if (vsFirst !== (VA + VF) * HT) $display("[TB] FAIL vsync_start got=%0d want=%0d", vsFirst, (VA + VF) * HT);
        else passed++;
        checks++;
        if (syncCnt !== 1) $display("[TB] FAIL sync_count got=%0d want=1", syncCnt);
        else passed++;
        checks++;
        if (syncAt !== VA * HT) $display("[TB] FAIL sync_position got=%0d want=%0d", syncAt, VA * HT);
        else passed++;
    endtask

    task automatic test_data_path();
        logic [7:0] seen[$];
        logic [7:0] want[4];
        int ackCnt = 0, consec = 0;
        logic prevAck = 1'b0;
        want[0] = {3'd7, 3'd0, 2'd0};
        want[1] = {3'd0, 3'd7, 2'd0};
        want[2] = {3'd0, 3'd0, 2'd3};
        want[3] = {3'd7, 3'd7, 2'd3};
        advance_to(1, VA);
        srcQ.push_back(8'hE0); srcQ.push_back(8'h1C);
        srcQ.push_back(8'h03); srcQ.push_back(8'hFF);
        for (int n = 0; n < HT * VT && seen.size() < 5; n++) begin
            tick();
            checks++;
            if (obsVec !== expVec)
                $display("[TB] FAIL data_model cyc=%0d got=%h want=%h", cycleNo, obsVec, expVec);
            else passed++;
            if (ack_i) begin
                ackCnt++;
                if (prevAck) consec++;
            end
            prevAck = ack_i;
            if (de) seen.push_back({r, g, b});
        end
        checks++;
        if (seen.size() < 5) begin
            $display("[TB] FAIL data_timeout got=%0d pixels want=5", seen.size());
        end else begin
            passed++;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seen[i] !== want[i])
                    $display("[TB] FAIL data_pixel%0d got=%h want=%h", i, seen[i], want[i]);
                else passed++;
            end
            checks++;
            if (seen[4] !== 8'h00) $display("[TB] FAIL data_black got=%h want=00", seen[4]);
            else passed++;
        end
        checks++;
        if (ackCnt !== 4) $display("[TB] FAIL data_ack_count got=%0d want=4", ackCnt);
        else passed++;
        checks++;
        if (consec !== 0) $display("[TB] FAIL data_ack_back_to_back got=%0d want=0", consec);
        else passed++;
    endtask

    task automatic test_backpressure();
        int ackCnt = 0;
        bit gotDe = 1'b0;
        advance_to(1, VA);
        for (int i = 0; i < 24; i++) srcQ.push_back(8'($urandom));
        for (int n = 0; n < HT * VT; n++) begin
            tick();
            checks++;
            if (obsVec !== expVec)
                $display("[TB] FAIL bp_model cyc=%0d got=%h want=%h", cycleNo, obsVec, expVec);
            else passed++;
            if (de) begin
                gotDe = 1'b1;
                break;
            end
            if (ack_i) ackCnt++;
        end
        checks++;
        if (!gotDe) $display("[TB] FAIL bp_timeout got=0 want=de");
        else passed++;
        checks++;
        if (ackCnt !== DEPTH) $display("[TB] FAIL bp_ack_count got=%0d want=%0d", ackCnt, DEPTH);
        else passed++;
        tick();
        checks++;
        if (ack_i !== 1'b1) $display("[TB] FAIL bp_ack_after_pop got=%b want=1", ack_i);
        else passed++;
        for (int n = 0; n < 3 * HT; n++) begin
            tick();
            checks++;
            if (obsVec !== expVec)
                $display("[TB] FAIL bp_stream cyc=%0d got=%h want=%h", cycleNo, obsVec, expVec);
            else passed++;
        end
    endtask

    // Five bytes are pushed late in the last visible line and are still
    // queued at the flush. Only the three bytes sent afterwards may appear.
    task automatic test_flush_underrun();
        logic [7:0] sent[8];
        logic [7:0] seen[$];
        bit syncSeen = 1'b0;
        advance_to(HT - 10, VA - 1);
        for (int i = 0; i < 8; i++) begin
            sent[i] = 8'($urandom);
            srcQ.push_back(sent[i]);
        end
        for (int n = 0; n < 2 * HT * VT && seen.size() < 4; n++) begin
            tick();
            checks++;
            if (obsVec !== expVec)
                $display("[TB] FAIL flush_model cyc=%0d got=%h want=%h", cycleNo, obsVec, expVec);
            else passed++;
            if (sync) begin
                syncSeen = 1'b1;
                checks++;
                if (ack_i !== 1'b0) $display("[TB] FAIL flush_no_ack got=%b want=0", ack_i);
                else passed++;
            end
            if (syncSeen && de) seen.push_back({r, g, b});
        end
        checks++;
        if (seen.size() < 4) begin
            $display("[TB] FAIL flush_timeout got=%0d pixels want=4", seen.size());
        end else begin
            passed++;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (seen[i] !== sent[5 + i])
                    $display("[TB] FAIL flush_pixel%0d got=%h want=%h", i, seen[i], sent[5 + i]);
                else passed++;
            end
            checks++;
            if (seen[3] !== 8'h00) $display("[TB] FAIL underrun_black got=%h want=00", seen[3]);
            else passed++;
            checks++;
            if (underrun !== 1'b1) $display("[TB] FAIL underrun_sticky got=%b want=1", underrun);
            else passed++;
        end
    endtask

    task automatic test_midframe_reset();
        int firstLow = -1;
        advance_to(1, VA + 1);
        for (int i = 0; i < 4; i++) srcQ.push_back(8'($urandom_range(1, 255)));
        advance_to(30, VA + 1);
        rst = 1'b0;
        tick();
        checks++;
        if (obsVec !== RESET_VEC)
            $display("[TB] FAIL midreset_outputs got=%h want=%h", obsVec, RESET_VEC);
        else passed++;
        rst = 1'b1;
        for (int n = 0; n < 2 * HT; n++) begin
            tick();
            checks++;
            if (obsVec !== expVec)
                $display("[TB] FAIL midreset_model cyc=%0d got=%h want=%h", cycleNo, obsVec, expVec);
            else passed++;
            if (n == 0) begin
                checks++;
                if ({de, r, g, b} !== 9'h100)
                    $display("[TB] FAIL midreset_fifo_lost got=%h want=100", {de, r, g, b});
                else passed++;
            end
            if (!hsync) begin
                firstLow = n;
                break;
            end
        end
        checks++;
        if (firstLow !== HA + HF)
            $display("[TB] FAIL midreset_hsync got=%0d want=%0d", firstLow, HA + HF);
        else passed++;
    endtask

    initial begin
        $display("[TB] vga_scanout bench start");
        test_reset();
        test_line_timing();
        test_data_path();
        test_backpressure();
        test_flush_underrun();
        test_midframe_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
